// File: rtl/pattern_matcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pattern_matcher                                             |
// | Purpose  : Streaming byte-pattern matcher between UART RX and TX.      |
// |            The first bytes after reset or reload are a length byte and |
// |            the pattern. Later bytes are text searched for the pattern, |
// |            including overlapping matches. Each match produces a        |
// |            one-byte position report through a 1-deep pending slot.     |
// | Options  : CASE_FOLD_EN - fold 'A'..'Z' to 'a'..'z' before storage     |
// |            and compare (case-insensitive matching).                    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module pattern_matcher #(
  parameter int PAT_MAX = 8,   // 2..16
  parameter int CNT_W   = 16   // must be >= 8 (reports carry pos[7:0])
) (
  input  logic             clk_s,
  input  logic             rstn_s,
  input  logic             iRELOAD,
  input  logic             iVALID,
  input  logic [7:0]       iDATA,
  input  logic             iTX_BUSY,
  output logic             oSEND,
  output logic [7:0]       oDATA,
  output logic             oMATCH,
  output logic [CNT_W-1:0] oCOUNT,
  output logic             oOVF,
  output logic [1:0]       oSTATE
);

  localparam int        LW        = $clog2(PAT_MAX + 1);
  localparam logic [7:0] C_PAT_MAX = 8'(PAT_MAX);

  typedef enum logic [1:0] {
    S_LOAD_LEN = 2'd0,
    S_LOAD_PAT = 2'd1,
    S_MATCH    = 2'd2
  } state_t;

  state_t           state_q;
  // Pattern is shifted in newest-first, so pat_q[k] lines up with win_q[k]
  // (both hold the k-th most recent byte) once loading is complete.
  logic [7:0]       pat_q [PAT_MAX];
  logic [7:0]       win_q [PAT_MAX];
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    idx_q;
  logic [LW-1:0]    fill_q;
  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] count_q;
  logic             slot_full_q;
  logic [7:0]       slot_data_q;
  logic             send_q;
  logic [7:0]       data_q;
  logic             match_q;
  logic             ovf_q;

  logic [7:0]       byte_in;
  logic [7:0]       win_d [PAT_MAX];
  logic [LW-1:0]    fill_inc;
  logic [LW-1:0]    fill_d;
  logic             eq;
  logic             report;
  logic             tx_free;

`ifdef CASE_FOLD_EN
  // Map upper-case ASCII to lower case for both pattern and text bytes
  always_comb begin
    byte_in = iDATA;
    if (iDATA >= 8'h41 && iDATA <= 8'h5A) byte_in = iDATA | 8'h20;
  end
`else
  assign byte_in = iDATA;
`endif

  // Window as it will look after this byte is shifted in (newest at 0)
  always_comb begin
    win_d[0] = byte_in;
    for (int k = 1; k < PAT_MAX; k++) win_d[k] = win_q[k-1];
  end

  // Compare the L newest bytes, including the incoming one, to the pattern
  always_comb begin
    eq = 1'b1;
    for (int k = 0; k < PAT_MAX; k++) begin
      if (LW'(k) < len_q && win_d[k] != pat_q[k]) eq = 1'b0;
    end
  end

  assign fill_inc = fill_q + LW'(1);
  assign fill_d   = (fill_inc > len_q) ? len_q : fill_inc;
  assign report   = (state_q == S_MATCH) && iVALID && !iRELOAD && eq &&
                    (fill_inc >= len_q);
  // A send in flight counts as busy so oSEND can never pulse back-to-back
  assign tx_free  = !iTX_BUSY && !send_q;

  // FSM, report path and all registered outputs
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state_q     <= S_LOAD_LEN;
      len_q       <= '0;
      idx_q       <= '0;
      fill_q      <= '0;
      pos_q       <= '0;
      count_q     <= '0;
      slot_full_q <= 1'b0;
      slot_data_q <= '0;
      send_q      <= 1'b0;
      data_q      <= '0;
      match_q     <= 1'b0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < PAT_MAX; k++) begin
        pat_q[k] <= '0;
        win_q[k] <= '0;
      end
    end else begin
      match_q <= report;
      send_q  <= 1'b0;

      // Report path: direct send, park in slot, or drop when slot is taken
      if (report) begin
        if (count_q != '1) count_q <= count_q + 1'b1;
        if (tx_free) begin
          send_q <= 1'b1;
          if (slot_full_q) begin
            // Older parked report goes first; the new one takes the slot
            data_q      <= slot_data_q;
            slot_data_q <= pos_q[7:0];
          end else begin
            data_q <= pos_q[7:0];
          end
        end else if (!slot_full_q) begin
          slot_full_q <= 1'b1;
          slot_data_q <= pos_q[7:0];
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (slot_full_q && tx_free) begin
        send_q      <= 1'b1;
        data_q      <= slot_data_q;
        slot_full_q <= 1'b0;
      end

      // Control: reload wins over any byte arriving in the same cycle
      if (iRELOAD) begin
        state_q <= S_LOAD_LEN;
        len_q   <= '0;
        idx_q   <= '0;
        fill_q  <= '0;
        pos_q   <= '0;
        count_q <= '0;
      end else if (iVALID) begin
        case (state_q)
          S_LOAD_LEN: begin
            if (iDATA != 8'd0 && iDATA <= C_PAT_MAX) begin
              len_q   <= iDATA[LW-1:0];
              idx_q   <= '0;
              state_q <= S_LOAD_PAT;
            end
          end
          S_LOAD_PAT: begin
            pat_q[0] <= byte_in;
            for (int k = 1; k < PAT_MAX; k++) pat_q[k] <= pat_q[k-1];
            idx_q <= idx_q + LW'(1);
            if (idx_q + LW'(1) == len_q) begin
              state_q <= S_MATCH;
              fill_q  <= '0;
              pos_q   <= '0;
              count_q <= '0;
              for (int k = 0; k < PAT_MAX; k++) win_q[k] <= '0;
            end
          end
          S_MATCH: begin
            win_q  <= win_d;
            fill_q <= fill_d;
            pos_q  <= pos_q + 1'b1;
          end
          default: state_q <= S_LOAD_LEN;
        endcase
      end
    end
  end

  assign oSEND  = send_q;
  assign oDATA  = data_q;
  assign oMATCH = match_q;
  assign oCOUNT = count_q;
  assign oOVF   = ovf_q;
  assign oSTATE = state_q;

endmodule
`default_nettype wire
